// File: rtl/rib_rr_arbiter.sv
// Registered round-robin arbiter for RIB masters; holds a grant until the slave returns ready.
// Optional forced release on a hung slave when RIB_ARB_TIMEOUT_EN is defined.
module rib_rr_arbiter #(
  parameter int unsigned NUM_M       = 4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M-1:0]         req_i,
  input  logic                     slv_ready_i,
  output logic [NUM_M-1:0]         grant_o,
  output logic [$clog2(NUM_M)-1:0] grant_idx_o,
  output logic                     gnt_valid_o,
  output logic [NUM_M-1:0]         stall_o,
  output logic                     done_o,
  output logic                     timeout_o
);

  localparam int unsigned IW = $clog2(NUM_M);

  if (NUM_M < 2 || NUM_M > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("rib_rr_arbiter: NUM_M must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q;
  logic [NUM_M-1:0]   grant_q;
  logic [IW-1:0]      grant_idx_q;
  logic [IW-1:0]      ptr_q;

  logic [IW-1:0]      nxt_ptr;
  logic               idle_found;
  logic [IW-1:0]      idle_idx;
  logic               rel_found;
  logic [IW-1:0]      rel_idx;
  logic               own_req;
  logic               release_now;
  logic               tout_hit;

  // First requester at or after p, wrapping modulo NUM_M.
  function automatic logic [IW:0] rr_pick(input logic [NUM_M-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]   res;
    logic [IW:0]   s;
    logic [IW-1:0] j;
    res = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      s = {1'b0, p} + (IW + 1)'(i);
      if (s >= (IW + 1)'(NUM_M)) s = s - (IW + 1)'(NUM_M);
      j = s[IW-1:0];
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  function automatic logic [NUM_M-1:0] onehot(input logic [IW-1:0] idx);
    return {{(NUM_M - 1){1'b0}}, 1'b1} << idx;
  endfunction

  always_comb begin
    nxt_ptr = (grant_idx_q == IW'(NUM_M - 1)) ? '0 : grant_idx_q + 1'b1;
    {idle_found, idle_idx} = rr_pick(req_i, ptr_q);
    {rel_found, rel_idx}   = rr_pick(req_i & ~grant_q, nxt_ptr);
  end

  assign gnt_valid_o = (state_q == StBusy);
  assign grant_o     = grant_q;
  assign grant_idx_o = grant_idx_q;
  assign own_req     = req_i[grant_idx_q];

  // A withdrawn request or a reset in the same cycle suppresses completion.
  assign done_o      = ~rst & gnt_valid_o & slv_ready_i & own_req;
  assign stall_o     = req_i & ~(grant_q & {NUM_M{gnt_valid_o & slv_ready_i}});

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q;

  assign tout_hit = ~rst & gnt_valid_o & own_req & ~slv_ready_i &
                    (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StBusy && own_req && !slv_ready_i && !tout_hit) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign tout_hit = 1'b0;
`endif

  assign timeout_o   = tout_hit;
  assign release_now = done_o | tout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_found) begin
            state_q     <= StBusy;
            grant_q     <= onehot(idle_idx);
            grant_idx_q <= idle_idx;
          end else begin
            grant_q     <= '0;
            grant_idx_q <= '0;
          end
        end
        StBusy: begin
          if (!own_req) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            grant_idx_q <= '0;
          end else if (release_now) begin
            ptr_q <= nxt_ptr;
            if (rel_found) begin
              grant_q     <= onehot(rel_idx);
              grant_idx_q <= rel_idx;
            end else begin
              state_q     <= StIdle;
              grant_q     <= '0;
              grant_idx_q <= '0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          grant_q     <= '0;
          grant_idx_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: directed vector table, random run against a
// behavioural round-robin model, and timeout / no-timeout hold sequences.
module tb_rib_rr_arbiter;

  localparam int N    = 4;
  localparam int TOUT = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rdy;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       valid;
  logic [3:0] stall;
  logic       done;
  logic       tout;

  int errors = 0;
  int checks = 0;

  // Model state: granted master (-1 when idle), priority pointer, busy-without-ready count.
  int mg;
  int mptr;
  int mcnt;

  rib_rr_arbiter #(
    .NUM_M       (N),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .slv_ready_i (rdy),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .gnt_valid_o (valid),
    .stall_o     (stall),
    .done_o      (done),
    .timeout_o   (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       rd;
    logic [3:0] g;
    logic [1:0] gi;
    logic       v;
    logic       d;
    logic [3:0] st;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic a, input logic [3:0] b, input logic c);
    @(negedge clk);
    rst = a;
    req = b;
    rdy = c;
    #1;
  endtask

  function automatic int mpick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_check();
    logic [3:0] eg;
    logic       ed;
    logic       et;
    eg = (mg >= 0) ? 4'(1 << mg) : 4'b0000;
    ed = !rst && mg >= 0 && rdy && req[mg];
`ifdef RIB_ARB_TIMEOUT_EN
    et = !rst && mg >= 0 && req[mg] && !rdy && mcnt == TOUT - 1;
`else
    et = 1'b0;
`endif
    chk("rnd_grant", 32'(grant), 32'(eg));
    chk("rnd_idx", 32'(gidx), (mg >= 0) ? 32'(mg) : 32'd0);
    chk("rnd_valid", 32'(valid), 32'(mg >= 0));
    chk("rnd_stall", 32'(stall), 32'(req & ~((mg >= 0 && rdy) ? eg : 4'b0000)));
    chk("rnd_done", 32'(done), 32'(ed));
    chk("rnd_timeout", 32'(tout), 32'(et));
    if (rst) begin
      mg = -1; mptr = 0; mcnt = 0;
    end else if (mg < 0) begin
      mg = mpick(req, mptr); mcnt = 0;
    end else if (!req[mg]) begin
      mg = -1; mcnt = 0;
    end else if (ed || et) begin
      mptr = (mg + 1) % N;
      mg = mpick(req & ~4'(1 << mg), mptr);
      mcnt = 0;
    end else begin
      mcnt++;
    end
  endtask

  initial begin
    logic [3:0] rq;
    logic       rd;
    logic       rr;
    int         slow;

    rst = 1'b1;
    req = 4'b1111;
    rdy = 1'b0;

    tbl[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1111};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 4'b1110};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b1101};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b1011};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 4'b0111};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0011};
    tbl[10] = '{1'b0, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 4'b0010};
    tbl[11] = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0011};
    tbl[12] = '{1'b0, 4'b0111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0101};
    tbl[13] = '{1'b0, 4'b0011, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0011};
    tbl[14] = '{1'b0, 4'b1011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b1011};
    tbl[15] = '{1'b0, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1, 4'b0011};
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0000};
    tbl[17] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100};
    tbl[18] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0000};
    tbl[19] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0100};
    tbl[20] = '{1'b0, 4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0001};

    // Reset held two cycles with all masters requesting.
    drive(1'b1, 4'b1111, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_idx", 32'(gidx), 32'd0);
    chk("rst_timeout", 32'(tout), 32'd0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].r, tbl[i].rq, tbl[i].rd);
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d_idx", i), 32'(gidx), 32'(tbl[i].gi));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].d));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].st));
      chk($sformatf("vec%0d_timeout", i), 32'(tout), 32'd0);
    end

    // Random traffic against the model, with phases of slow slaves.
    drive(1'b1, 4'b0000, 1'b0);
    model_check();
    rq = 4'b0000;
    slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) slow = ($urandom_range(0, 2) == 0) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      rd = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 149) == 0);
      drive(rr, rq, rd);
      model_check();
    end

    // Hung slave: master 1 granted, ready never asserted.
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b0, 4'b0110, 1'b0);
    chk("hang_idle_valid", 32'(valid), 32'd0);
`ifdef RIB_ARB_TIMEOUT_EN
    for (int c = 1; c <= TOUT; c++) begin
      drive(1'b0, 4'b0110, 1'b0);
      chk($sformatf("tout_grant_c%0d", c), 32'(grant), 32'b0010);
      chk($sformatf("tout_pulse_c%0d", c), 32'(tout), 32'(c == TOUT));
    end
    drive(1'b0, 4'b0110, 1'b0);
    chk("tout_next_grant", 32'(grant), 32'b0100);
    chk("tout_next_pulse", 32'(tout), 32'd0);
`else
    for (int c = 1; c <= 1000; c++) begin
      drive(1'b0, 4'b0110, 1'b0);
      chk("hold_grant", 32'(grant), 32'b0010);
      chk("hold_timeout", 32'(tout), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
